// File: rtl/lz77_min_match_filter.sv
// LZ77 minimum-match filter with valid/ready stream interface.
// Matches shorter than MIN_MATCH are expanded into literals from a short history of absorbed symbols.
module lz77_min_match_filter #(
    parameter int DATA_WIDTH           = 8,
    parameter int DICTIONARY_DEPTH_LOG = 16,
    parameter int CNT_WIDTH            = 9,
    parameter int MIN_MATCH            = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_symbol,
    input  logic                            in_tuple,
    input  logic [DICTIONARY_DEPTH_LOG:0]   in_position,
    input  logic [CNT_WIDTH-1:0]            in_length,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DICTIONARY_DEPTH_LOG:0]   out_position,
    output logic [CNT_WIDTH-1:0]            out_length,
    output logic [DATA_WIDTH-1:0]           out_next_symbol,
    output logic                            out_match_valid,
    output logic                            out_last,
    output logic                            proto_err,
    output logic                            dbg_state
);

    localparam int H  = MIN_MATCH - 1;
    localparam int HW = $clog2(MIN_MATCH);

    typedef enum logic {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

    // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
    // valid never waits on ready, and ready never depends combinationally on valid.

    state_t                          state_q, state_d;
    logic [H*DATA_WIDTH-1:0]         hist_q, hist_d;
    logic [HW-1:0]                   hist_cnt_q, hist_cnt_d;
    logic [HW-1:0]                   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]           pend_sym_q, pend_sym_d;
    logic                            pend_last_q, pend_last_d;
    logic                            err_q, err_d;
    logic                            out_valid_q, out_valid_d;
    logic [DICTIONARY_DEPTH_LOG:0]   out_pos_q, out_pos_d;
    logic [CNT_WIDTH-1:0]            out_len_q, out_len_d;
    logic [DATA_WIDTH-1:0]           out_sym_q, out_sym_d;
    logic                            out_last_q, out_last_d;
    logic                            out_load;
    logic                            accept;
    int                              sel_idx;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        hist_cnt_d  = hist_cnt_q;
        rem_d       = rem_q;
        pend_sym_d  = pend_sym_q;
        pend_last_d = pend_last_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_pos_d   = out_pos_q;
        out_len_d   = out_len_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;
        sel_idx     = 0;

        out_load = ~out_valid_q | out_ready;
        in_ready = (state_q == S_IDLE) & out_load & ~rst;
        accept   = in_valid & in_ready;

        // A consumed beat with nothing new to present leaves the register empty.
        if (out_load) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && !in_tuple) begin
                    for (int i = H - 1; i > 0; i--) begin
                        hist_d[i*DATA_WIDTH +: DATA_WIDTH] = hist_q[(i-1)*DATA_WIDTH +: DATA_WIDTH];
                    end
                    hist_d[0 +: DATA_WIDTH] = in_symbol;
                    if (hist_cnt_q != HW'(H)) begin
                        hist_cnt_d = hist_cnt_q + HW'(1);
                    end
                    if (in_last) begin
                        err_d = 1'b1;
                    end
                end else if (accept) begin
                    hist_cnt_d  = '0;
                    out_valid_d = 1'b1;
                    out_pos_d   = '0;
                    out_len_d   = '0;
                    out_sym_d   = in_symbol;
                    out_last_d  = in_last;
                    if (in_length >= CNT_WIDTH'(MIN_MATCH)) begin
                        out_pos_d = in_position;
                        out_len_d = in_length;
                        if (hist_cnt_q != HW'(H)) begin
                            err_d = 1'b1;
                        end
                    end else if (in_length != '0) begin
                        // Oldest matched symbol goes out first; the tuple's own symbol waits.
                        sel_idx     = int'(in_length) - 1;
                        out_sym_d   = hist_q[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                        out_last_d  = 1'b0;
                        pend_sym_d  = in_symbol;
                        pend_last_d = in_last;
                        rem_d       = HW'(in_length - CNT_WIDTH'(1));
                        state_d     = S_EXPAND;
                        if (CNT_WIDTH'(hist_cnt_q) != in_length) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_EXPAND: begin
                if (out_load) begin
                    out_valid_d = 1'b1;
                    out_pos_d   = '0;
                    out_len_d   = '0;
                    if (rem_q != '0) begin
                        sel_idx    = int'(rem_q) - 1;
                        out_sym_d  = hist_q[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                        out_last_d = 1'b0;
                        rem_d      = rem_q - HW'(1);
                    end else begin
                        out_sym_d  = pend_sym_q;
                        out_last_d = pend_last_q;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hist_q      <= '0;
            hist_cnt_q  <= '0;
            rem_q       <= '0;
            pend_sym_q  <= '0;
            pend_last_q <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_pos_q   <= '0;
            out_len_q   <= '0;
            out_sym_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            hist_cnt_q  <= hist_cnt_d;
            rem_q       <= rem_d;
            pend_sym_q  <= pend_sym_d;
            pend_last_q <= pend_last_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_pos_q   <= out_pos_d;
            out_len_q   <= out_len_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_position    = out_pos_q;
    assign out_length      = out_len_q;
    assign out_next_symbol = out_sym_q;
    assign out_match_valid = out_valid_q;
    assign out_last        = out_last_q;
    assign proto_err       = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_lz77_min_match_filter.sv
// Bench for lz77_min_match_filter: MIN_MATCH=3 instance with a queue-based reference model,
// plus a MIN_MATCH=5 instance exercised with directed steps.
module tb_lz77_min_match_filter;

    typedef struct packed {
        logic [16:0] pos;
        logic [8:0]  len;
        logic [7:0]  sym;
        logic        last;
    } beat_t;

    localparam int M3 = 3;
    localparam int H3 = M3 - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid = 0, in_tuple = 0, in_last = 0, out_ready = 1;
    logic [7:0]  in_symbol = 0;
    logic [16:0] in_position = 0;
    logic [8:0]  in_length = 0;
    logic        in_ready, out_valid, out_match_valid, out_last, proto_err, dbg_state;
    logic [16:0] out_position;
    logic [8:0]  out_length;
    logic [7:0]  out_next_symbol;

    logic        v5 = 0, tup5 = 0, last5 = 0, ordy5 = 1;
    logic [7:0]  sym5 = 0;
    logic [16:0] pos5 = 0;
    logic [8:0]  len5 = 0;
    logic        irdy5, ov5, omv5, olast5, err5, dbg5;
    logic [16:0] opos5;
    logic [8:0]  olen5;
    logic [7:0]  osym5;

    int    n_cmp = 0;
    int    n_mis = 0;
    int    cyc = 0;
    bit    rdy_rand = 0;
    beat_t exp_q[$];
    logic [7:0] mh[$];
    int    mcnt = 0;
    logic  err_exp = 0;

    lz77_min_match_filter #(.MIN_MATCH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_symbol(in_symbol), .in_tuple(in_tuple), .in_position(in_position),
        .in_length(in_length), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_position(out_position), .out_length(out_length),
        .out_next_symbol(out_next_symbol), .out_match_valid(out_match_valid),
        .out_last(out_last), .proto_err(proto_err), .dbg_state(dbg_state)
    );

    lz77_min_match_filter #(.MIN_MATCH(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_ready(irdy5),
        .in_symbol(sym5), .in_tuple(tup5), .in_position(pos5),
        .in_length(len5), .in_last(last5), .out_valid(ov5),
        .out_ready(ordy5), .out_position(opos5), .out_length(olen5),
        .out_next_symbol(osym5), .out_match_valid(omv5),
        .out_last(olast5), .proto_err(err5), .dbg_state(dbg5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mh.delete();
        for (int i = 0; i < H3; i++) mh.push_back(8'h00);
        mcnt = 0;
        err_exp = 0;
    endtask

    // Reference: history as a queue (newest at front), outputs appended per tuple.
    task automatic model_accept();
        int L;
        beat_t b;
        if (!in_tuple) begin
            mh.push_front(in_symbol);
            void'(mh.pop_back());
            if (mcnt < H3) mcnt++;
            if (in_last) err_exp = 1;
        end else begin
            L = int'(in_length);
            if (L == 0) begin
                b = '{pos: 0, len: 0, sym: in_symbol, last: in_last};
                exp_q.push_back(b);
            end else if (L >= M3) begin
                if (mcnt != H3) err_exp = 1;
                b = '{pos: in_position, len: in_length, sym: in_symbol, last: in_last};
                exp_q.push_back(b);
            end else begin
                if (mcnt != L) err_exp = 1;
                for (int k = L - 1; k >= 0; k--) begin
                    b = '{pos: 0, len: 0, sym: mh[k], last: 1'b0};
                    exp_q.push_back(b);
                end
                b = '{pos: 0, len: 0, sym: in_symbol, last: in_last};
                exp_q.push_back(b);
            end
            mcnt = 0;
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            check("proto_err", proto_err, err_exp);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("out_position", out_position, e.pos);
                    check("out_length", out_length, e.len);
                    check("out_next_symbol", out_next_symbol, e.sym);
                    check("out_last", out_last, e.last);
                    check("out_match_valid", out_match_valid, 1);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) model_accept();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input bit tup, input logic [7:0] sym, input logic [16:0] pos,
                        input logic [8:0] len, input bit last);
        bit done;
        done = 0;
        in_valid = 1; in_tuple = tup; in_symbol = sym;
        in_position = pos; in_length = len; in_last = last;
        for (int k = 0; k < 200 && !done; k++) begin
            if (in_ready) done = 1;
            step();
        end
        in_valid = 0;
        if (!done) check("send_timeout", 1, 0);
    endtask

    task automatic send5(input bit tup, input logic [7:0] sym, input logic [8:0] len, input bit last);
        bit done;
        done = 0;
        v5 = 1; tup5 = tup; sym5 = sym; pos5 = 17'd9; len5 = len; last5 = last;
        for (int k = 0; k < 200 && !done; k++) begin
            if (irdy5) done = 1;
            step();
        end
        v5 = 0;
        if (!done) check("send5_timeout", 1, 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 500) begin
            step();
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int r;
        int L;
        model_reset();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_fields", {out_position, out_length, out_next_symbol, out_last, out_match_valid}, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_state", dbg_state, 0);
        check("rst_out_valid5", ov5, 0);
        step(); step();
        rst = 0;
        step();

        // Short match expands into literals A, B, C
        send(0, "A", 0, 0, 0);
        send(0, "B", 0, 0, 0);
        send(1, "C", 17'd5, 9'd2, 0);
        check("s1_first_lit_valid", out_valid, 1);
        check("s1_first_lit_sym", out_next_symbol, "A");
        check("s1_in_ready_c0", in_ready, 0);
        step();
        check("s1_in_ready_c1", in_ready, 0);
        check("s1_second_lit_sym", out_next_symbol, "B");
        step();
        check("s1_in_ready_c2", in_ready, 1);
        check("s1_third_lit_sym", out_next_symbol, "C");
        drain();

        // Long match passes through without bubbles
        c0 = cyc;
        send(0, "x", 0, 0, 0);
        send(0, "y", 0, 0, 0);
        send(0, "z", 0, 0, 0);
        send(0, "w", 0, 0, 0);
        send(1, "q", 17'd17, 9'd4, 0);
        check("s2_no_bubbles", cyc - c0, 5);
        check("s2_out_valid", out_valid, 1);
        check("s2_out_length", out_length, 4);
        check("s2_out_position", out_position, 17);
        drain();

        // Literal carrying end of stream
        send(1, 8'h41, 0, 0, 1);
        check("s3_out_last", out_last, 1);
        check("s3_out_sym", out_next_symbol, 8'h41);
        drain();

        // Same short match under output stalls
        send(0, "A", 0, 0, 0);
        send(0, "B", 0, 0, 0);
        send(1, "C", 17'd5, 9'd2, 0);
        out_ready = 1; step();
        out_ready = 0; step();
        out_ready = 0; step();
        out_ready = 1; step();
        out_ready = 1; step();
        drain();

        // Randomized legal stream with random backpressure
        rdy_rand = 1;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                send(1, 8'($urandom), 17'($urandom), 0, ($urandom_range(0, 7) == 0));
            end else if (r == 1) begin
                for (int a = 0; a < H3 + int'($urandom_range(0, 2)); a++) send(0, 8'($urandom), 0, 0, 0);
                send(1, 8'($urandom), 17'($urandom_range(1, 65535)), 9'($urandom_range(3, 40)),
                     ($urandom_range(0, 7) == 0));
            end else begin
                L = $urandom_range(1, H3);
                for (int a = 0; a < L; a++) send(0, 8'($urandom), 0, 0, 0);
                send(1, 8'($urandom), 17'($urandom), 9'(L), ($urandom_range(0, 7) == 0));
            end
        end
        rdy_rand = 0;
        out_ready = 1;
        drain();

        // MIN_MATCH=5 instance: four-deep expansion with end of stream
        for (int s = 1; s <= 4; s++) send5(0, 8'(s), 0, 0);
        send5(1, 8'd5, 9'd4, 1);
        for (int s = 1; s <= 5; s++) begin
            check("m5_valid", ov5, 1);
            check("m5_sym", osym5, s);
            check("m5_last", olast5, (s == 5));
            check("m5_len", olen5, 0);
            step();
        end
        check("m5_idle_after", ov5, 0);
        check("m5_no_err", err5, 0);
        send5(0, 8'd6, 0, 0);
        send5(0, 8'd7, 0, 0);
        send5(1, 8'd8, 9'd3, 0);
        check("m5_err_set", err5, 1);
        for (int k = 0; k < 6; k++) step();
        check("m5_err_sticky", err5, 1);

        // Reset in the middle of an expansion
        send(0, "A", 0, 0, 0);
        send(0, "B", 0, 0, 0);
        send(1, "C", 17'd5, 9'd2, 0);
        check("s6_first_lit", out_next_symbol, "A");
        #2;
        rst = 1;
        model_reset();
        #1;
        check("s6_out_valid", out_valid, 0);
        check("s6_state", dbg_state, 0);
        check("s6_in_ready", in_ready, 0);
        check("s6_err5_cleared", err5, 0);
        step();
        rst = 0;
        step();
        send(1, 8'h5A, 0, 0, 1);
        check("s6_post_rst_valid", out_valid, 1);
        check("s6_post_rst_sym", out_next_symbol, 8'h5A);
        check("s6_post_rst_last", out_last, 1);
        drain();

        // End of stream on an absorbed beat is a protocol error
        send(0, "z", 0, 0, 1);
        check("pe_last_on_absorb", proto_err, 1);
        step(); step();
        check("pe_sticky", proto_err, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
